// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared FSM type, counter constants and saturating step for the gshare predictor
package bp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Widest counter the table supports; narrower counters live in the low bits.
    localparam int CTR_MAX_BITS = 4;

    // Strongly-taken value written to every entry during the INIT sweep.
    localparam logic [CTR_MAX_BITS-1:0] CTR_ALL_ONES = '1;

    // One saturating step of a ctr_bits-wide counter: up on taken, down otherwise.
    function automatic logic [CTR_MAX_BITS-1:0] sat_next(
        input logic [CTR_MAX_BITS-1:0] ctr,
        input logic                    taken,
        input int                      ctr_bits
    );
        logic [CTR_MAX_BITS-1:0] top;
        top = CTR_ALL_ONES >> (CTR_MAX_BITS - ctr_bits);
        if (taken) begin
            sat_next = (ctr >= top) ? top : ctr + 4'd1;
        end else begin
            sat_next = (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
        end
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - saturating counter array with read port, read-modify-write update port and INIT sweep pointer
module bp_counter_table #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_en,
    output logic                  init_last,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [CTR_BITS-1:0]   rd_ctr,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken
);
    import bp_pkg::*;

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0]     ctr_mem [ENTRIES];
    logic [INDEX_BITS-1:0]   ptr;
    logic [CTR_MAX_BITS-1:0] upd_old;
    logic [CTR_MAX_BITS-1:0] upd_new;

    // Asynchronous read: the caller registers the result, so a write on the
    // same edge is seen only by the following request (read-before-write).
    assign rd_ctr    = ctr_mem[rd_index];
    assign init_last = (ptr == {INDEX_BITS{1'b1}});

    // Widen the entry being trained to the package width and take one saturating step.
    always_comb begin
        upd_old                 = '0;
        upd_old[CTR_BITS-1:0]   = ctr_mem[upd_index];
        upd_new                 = sat_next(upd_old, upd_taken, CTR_BITS);
    end

    // INIT sweep pointer: restarts at entry 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (init_en) begin
            ptr <= ptr + INDEX_BITS'(1);
        end
    end

    // Counter storage: sweep writes strongly-taken during INIT, training writes afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_en) begin
                ctr_mem[ptr] <= CTR_ALL_ONES[CTR_BITS-1:0];
            end else if (upd_en) begin
                ctr_mem[upd_index] <= upd_new[CTR_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch direction predictor: FSM, history, index hash, mispredict counter
module gshare_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 4,
    parameter int PC_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  req_valid,
    input  logic [PC_BITS-1:0]    req_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic [15:0]           mispredict_cnt
);
    import bp_pkg::*;

    bp_state_e             state_q;
    bp_state_e             state_d;
    logic                  init_en;
    logic                  init_last;
    logic                  req_fire;
    logic                  upd_fire;
    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] req_idx;
    logic [CTR_BITS-1:0]   rd_ctr;

    // Next-state and INIT/busy decode; requests and updates only act in RUN.
    always_comb begin
        state_d  = state_q;
        init_en  = 1'b0;
        busy     = 1'b0;
        req_fire = 1'b0;
        upd_fire = 1'b0;
        case (state_q)
            INIT: begin
                init_en = 1'b1;
                busy    = 1'b1;
                if (init_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_fire = req_valid;
                upd_fire = upd_valid;
            end
            default: state_d = INIT;
        endcase
    end

    // State register: any reset restarts the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        if (HIST_BITS > 0) begin : g_hist
            logic [HIST_BITS-1:0] hist_q;
            logic [HIST_BITS:0]   hist_shift;

            assign hist_shift = {hist_q, upd_taken};

            // Non-speculative history: shifts only when a resolved branch returns.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_q <= '0;
                end else if (upd_fire) begin
                    hist_q <= hist_shift[HIST_BITS-1:0];
                end
            end

            // Zero-extend history to the index width for the XOR hash.
            always_comb begin
                hist_ext                  = '0;
                hist_ext[HIST_BITS-1:0]   = hist_q;
            end
        end else begin : g_no_hist
            assign hist_ext = '0;
        end
    endgenerate

    // Word-aligned PC bits select the entry; bits outside the index are not hashed.
    assign req_idx = req_pc[INDEX_BITS+1:2] ^ hist_ext;

    generate
        if (PC_BITS > INDEX_BITS + 2) begin : g_pc_hi
            logic unused_pc;
            assign unused_pc = ^{req_pc[PC_BITS-1:INDEX_BITS+2], req_pc[1:0]};
        end else begin : g_pc_lo
            logic unused_pc;
            assign unused_pc = ^req_pc[1:0];
        end
    endgenerate

    bp_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .init_en   (init_en),
        .init_last (init_last),
        .rd_index  (req_idx),
        .rd_ctr    (rd_ctr),
        .upd_en    (upd_fire),
        .upd_index (upd_index),
        .upd_taken (upd_taken)
    );

    // Prediction register: one-cycle pulse, index and direction held until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= req_fire;
            if (req_fire) begin
                pred_index <= req_idx;
                pred_taken <= rd_ctr[CTR_BITS-1];
            end
        end
    end

    // Saturating mispredict counter for performance monitoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (upd_fire && (upd_pred != upd_taken) && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed self-checking bench for gshare_predictor
module tb_gshare_predictor;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [5:0]  pred_index;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic        upd_pred;
    logic [15:0] mispredict_cnt;

    int          total;
    int          bad;
    logic [3:0]  exp_hist;
    int          n_busy;
    bit          pv_seen;

    gshare_predictor #(
        .INDEX_BITS (6),
        .CTR_BITS   (2),
        .HIST_BITS  (4),
        .PC_BITS    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .busy           (busy),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .upd_pred       (upd_pred),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_upd(input logic [5:0] idx, input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = taken;
        upd_pred  = pred;
        tick();
        upd_valid = 1'b0;
        exp_hist  = {exp_hist[2:0], taken};
    endtask

    task automatic pred_chk(input string tag, input logic [5:0] idx, input logic exp_taken);
        req_pc    = {24'd0, idx ^ {2'b00, exp_hist}, 2'b00};
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_valid"}, pred_valid, 1'b1);
        chk({tag, "_index"}, pred_index, idx);
        chk({tag, "_taken"}, pred_taken, exp_taken);
    endtask

    task automatic busy_count(output int n, output bit pv);
        req_valid = 1'b1;
        req_pc    = 32'h1234;
        n  = 0;
        pv = 1'b0;
        do begin
            tick();
            n++;
            if (pred_valid) pv = 1'b1;
        end while (busy && n < 200);
        req_valid = 1'b0;
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        total     = 0;
        bad       = 0;
        exp_hist  = 4'h0;

        repeat (3) tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_pred_valid", pred_valid, 1'b0);
        chk("rst_pred_taken", pred_taken, 1'b0);
        chk("rst_pred_index", pred_index, 6'd0);
        chk("rst_mispredict", mispredict_cnt, 16'd0);

        rst = 1'b0;
        busy_count(n_busy, pv_seen);
        chk("init_busy_cycles", n_busy, 64);
        chk("init_no_pred_valid", pv_seen, 1'b0);
        chk("init_pred_valid_at_exit", pred_valid, 1'b0);

        req_pc    = 32'h1234;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("first_valid", pred_valid, 1'b1);
        chk("first_index", pred_index, 6'h0D);
        chk("first_taken", pred_taken, 1'b1);
        tick();
        chk("pulse_drop", pred_valid, 1'b0);

        // Index 5 walks down 3->2->1->0, holds, then back up 1,2,3,3
        do_upd(6'd5, 1'b0, 1'b0); pred_chk("dn1", 6'd5, 1'b1);
        do_upd(6'd5, 1'b0, 1'b0); pred_chk("dn2", 6'd5, 1'b0);
        do_upd(6'd5, 1'b0, 1'b0); pred_chk("dn3", 6'd5, 1'b0);
        do_upd(6'd5, 1'b0, 1'b0); pred_chk("dn_hold", 6'd5, 1'b0);
        do_upd(6'd5, 1'b1, 1'b1); pred_chk("up1", 6'd5, 1'b0);
        do_upd(6'd5, 1'b1, 1'b1); pred_chk("up2", 6'd5, 1'b1);
        do_upd(6'd5, 1'b1, 1'b1); pred_chk("up3", 6'd5, 1'b1);
        do_upd(6'd5, 1'b1, 1'b1); pred_chk("up_hold", 6'd5, 1'b1);

        // History pattern 1,0,1,1 -> 0xB; pc 0x40 hashes to 0x10 ^ 0xB
        do_upd(6'd40, 1'b1, 1'b1);
        do_upd(6'd40, 1'b0, 1'b0);
        do_upd(6'd40, 1'b1, 1'b1);
        do_upd(6'd40, 1'b1, 1'b1);
        req_pc    = 32'h40;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("hist_valid", pred_valid, 1'b1);
        chk("hist_index", pred_index, 6'h1B);
        chk("hist_taken", pred_taken, 1'b1);

        // Index 7 to counter 2, then same-cycle request and not-taken update
        do_upd(6'd7, 1'b0, 1'b0);
        req_pc    = {24'd0, 6'd7 ^ {2'b00, exp_hist}, 2'b00};
        req_valid = 1'b1;
        upd_valid = 1'b1;
        upd_index = 6'd7;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        tick();
        req_valid = 1'b0;
        upd_valid = 1'b0;
        exp_hist  = {exp_hist[2:0], 1'b0};
        chk("rbw_valid", pred_valid, 1'b1);
        chk("rbw_index", pred_index, 6'd7);
        chk("rbw_taken_old", pred_taken, 1'b1);
        pred_chk("rbw_after", 6'd7, 1'b0);

        // Mispredict counting and saturation
        chk("mis_zero", mispredict_cnt, 16'd0);
        do_upd(6'd50, 1'b1, 1'b0);
        do_upd(6'd50, 1'b0, 1'b1);
        do_upd(6'd50, 1'b1, 1'b0);
        do_upd(6'd50, 1'b1, 1'b1);
        do_upd(6'd50, 1'b0, 1'b0);
        chk("mis_three", mispredict_cnt, 16'd3);
        upd_valid = 1'b1;
        upd_index = 6'd50;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        repeat (65531) tick();
        upd_valid = 1'b0;
        exp_hist  = 4'hF;
        chk("mis_fffe", mispredict_cnt, 16'hFFFE);
        do_upd(6'd50, 1'b1, 1'b0);
        chk("mis_ffff", mispredict_cnt, 16'hFFFF);
        do_upd(6'd50, 1'b1, 1'b0);
        chk("mis_sat", mispredict_cnt, 16'hFFFF);

        // Reset in the middle of INIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h1234;
        pv_seen   = 1'b0;
        repeat (20) begin
            tick();
            if (pred_valid) pv_seen = 1'b1;
        end
        chk("midinit_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("midinit_rst_mis", mispredict_cnt, 16'd0);
        chk("midinit_rst_pv", pred_valid | pv_seen, 1'b0);
        rst = 1'b0;
        busy_count(n_busy, pv_seen);
        exp_hist = 4'h0;
        chk("midinit_busy_cycles", n_busy, 64);
        chk("midinit_no_pred_valid", pv_seen, 1'b0);
        chk("midinit_mis", mispredict_cnt, 16'd0);
        pred_chk("midinit_hist0", 6'h0D, 1'b1);

        // Reset in RUN with a prediction in flight
        do_upd(6'd3, 1'b1, 1'b0);
        chk("run_mis_one", mispredict_cnt, 16'd1);
        req_pc    = 32'h1234;
        req_valid = 1'b1;
        tick();
        chk("run_inflight", pred_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("run_rst_pv", pred_valid, 1'b0);
        chk("run_rst_busy", busy, 1'b1);
        chk("run_rst_index", pred_index, 6'd0);
        chk("run_rst_mis", mispredict_cnt, 16'd0);
        rst = 1'b0;
        busy_count(n_busy, pv_seen);
        exp_hist = 4'h0;
        chk("run_busy_cycles", n_busy, 64);
        chk("run_no_pred_valid", pv_seen, 1'b0);
        pred_chk("run_reinit7", 6'd7, 1'b1);
        chk("run_mis_after", mispredict_cnt, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised branch direction predictor: a table of 2^INDEX_BITS saturating counters indexed by PC XOR global history. Supersedes the single 2-bit counter predictor in the fetch path. Gives a registered taken/not-taken prediction one cycle after a request, and trains on resolved outcomes returned from execute. Keeps a saturating mispredict count for performance monitoring.

## Interface
- INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries
- CTR_BITS, 2, counter width; legal range 1..4
- HIST_BITS, 4, global history length; 0 selects pure bimodal mode; must be ≤ INDEX_BITS
- PC_BITS, 32, PC width; must be ≥ INDEX_BITS+2

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- busy  out  1  high while the table initialises; requests are ignored
- req_valid  in  1  prediction request
- req_pc  in  PC_BITS  PC of the branch
- pred_valid  out  1  prediction valid, one cycle after an accepted request
- pred_taken  out  1  predicted direction (counter MSB)
- pred_index  out  INDEX_BITS  table index used; the caller must return it on update
- upd_valid  in  1  resolved-branch update
- upd_index  in  INDEX_BITS  index returned from pred_index
- upd_taken  in  1  actual direction
- upd_pred  in  1  direction that was predicted for this branch
- mispredict_cnt  out  16  saturating count of updates with upd_pred != upd_taken

## Operation
- FSM states: INIT, RUN. rst → INIT, init pointer = 0.
- INIT: each cycle write all-ones (strongly taken) to entry[ptr], then ptr++. After the write to entry 2^INDEX_BITS−1, go to RUN. busy=1 throughout INIT; req_valid and upd_valid are ignored.
- RUN: an accepted request computes idx = req_pc[INDEX_BITS+1:2] XOR zero-extended history[HIST_BITS-1:0], registers pred_index=idx and pred_taken=entry[idx][CTR_BITS-1], and asserts pred_valid for one cycle.
- Update (RUN, upd_valid):
  - if upd_taken: entry[upd_index] increments, saturating at 2^CTR_BITS−1; otherwise it decrements, saturating at 0.
  - history ← {history[HIST_BITS-2:0], upd_taken}. History is non-speculative and changes only on updates.
  - mispredict_cnt increments if upd_pred != upd_taken, saturating at 0xFFFF.
- Request and update in the same cycle to the same index: the prediction uses the pre-update counter (read-before-write). The request index uses the pre-update history.
- HIST_BITS=0: history logic is absent and idx = PC bits only.
- Reset values: busy=1 in the cycle after rst, pred_valid=0, pred_taken=0, pred_index=0, history=0, mispredict_cnt=0.
- rst asserted mid-operation, including mid-INIT: restart INIT from ptr 0, drop any pending pred_valid, clear history and counter.

## Timing
- Prediction latency is exactly 1 cycle (req_valid at cycle N → pred_valid at N+1). One request per cycle is sustained in RUN.
- An update takes effect for requests issued from the next cycle onward.
- INIT lasts 2^INDEX_BITS cycles after the cycle rst is sampled low. busy falls in the cycle the FSM enters RUN.
- No backpressure. pred_valid is a single-cycle pulse; the consumer must capture it.

## Structure
- Package bp_pkg holds:
  - function sat_next(ctr, taken, CTR_BITS): the saturating step
  - FSM state enum {INIT, RUN}
  - the all-ones reset constant
- Sub-module bp_counter_table holds the counter array with one read port and one write port (read-before-write), plus the INIT sweep pointer. The top level holds the FSM, history, index hashing and the mispredict counter.

## Test plan
- Reset, INDEX_BITS=6: busy high for exactly 64 cycles. A request right after busy falls returns pred_taken=1 for any PC. Requests issued during busy produce no pred_valid.
- Three not-taken updates to index 5 (CTR_BITS=2): counter goes 3→2→1→0. Prediction flips to 0 after the second update. A fourth update holds at 0. Then four taken updates give 1,2,3,3.
- HIST_BITS=4, updates with taken pattern 1,0,1,1 → history=0b1011. A request with req_pc=0x40 gives pred_index = 0x10 XOR 0xB = 0x1B.
- Same-cycle request and update to index 7, counter=2, upd_taken=0: pred_taken=1 (old value). The following request to index 7 gives pred_taken=0.
- mispredict_cnt: 3 updates with upd_pred≠upd_taken and 2 matching → 3. Force 0xFFFF, then mispredict → stays 0xFFFF.
- Assert rst at INIT cycle 20 and at a RUN cycle with a request in flight. INIT restarts with a full 64-cycle busy, no pred_valid appears, and history and mispredict_cnt read 0.
